arb_mux: RTL

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/arb_mux.sv
// arb_mux -- N-channel to 1 multiplexer with a single registered output slot.
//
// Purpose:
//   Selects one of NCH input channels and moves its word into a one-entry
//   output register. The channel is either picked directly by `sel` (fixed
//   mode) or by a round-robin scan that starts at a rotating pointer.
//   Valid/ready handshakes on both sides; one word per cycle when the
//   downstream keeps out_ready high.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst_n      in   synchronous, active-low reset
//   mode       in   0 = fixed select, 1 = round-robin
//   sel        in   [SELW-1:0] channel index used in fixed mode
//   in_data    in   [NCH*WIDTH-1:0] channel k at [k*WIDTH +: WIDTH]
//   in_valid   in   [NCH-1:0] per-channel valid
//   in_ready   out  [NCH-1:0] per-channel ready (combinational)
//   out_data   out  [WIDTH-1:0] registered selected word
//   out_valid  out  registered output valid
//   out_ready  in   downstream ready
//   out_ch     out  [SELW-1:0] channel that supplied out_data
module arb_mux #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  // Number of codes a SELW-bit index can take; channels above NCH-1 are
  // padded with zero so every index lookup stays in range.
  localparam int            NSLOT   = 2 ** SELW;
  localparam logic [SELW:0] NCH_W   = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [WIDTH-1:0] ch_data [NSLOT];
  logic [NSLOT-1:0] valid_pad;

  logic             load_en;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic             transfer;

  logic             rr_found;
  logic [SELW-1:0]  rr_idx;
  logic [SELW:0]    scan_sum;

  // Unpack channel data into an indexable array, zero-filling unused codes.
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NCH) begin : g_real
        assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign ch_data[gi] = '0;
      end
    end
  endgenerate

  assign valid_pad = NSLOT'(in_valid);

  // The single output slot can accept a word when empty or being drained.
  assign load_en = !out_valid_q || out_ready;

  // Round-robin scan: first valid channel at or after ptr, wrapping at NCH.
  // The modulo is done by one conditional subtract because ptr < NCH and
  // the offset is < NCH, so the sum is always below 2*NCH.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    scan_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      scan_sum = {1'b0, ptr_q} + (SELW+1)'(i);
      if (scan_sum >= NCH_W) begin
        scan_sum = scan_sum - NCH_W;
      end
      if (!rr_found && valid_pad[scan_sum[SELW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = scan_sum[SELW-1:0];
      end
    end
  end

  // Grant selection. In fixed mode the grant does not depend on in_valid,
  // so ready is offered to the selected channel even while it is idle.
  always_comb begin
    if (mode) begin
      grant_valid = rr_found;
      grant_idx   = rr_idx;
    end else begin
      grant_valid = ({1'b0, sel} < NCH_W);
      grant_idx   = sel;
    end
  end

  assign transfer = rst_n && load_en && grant_valid && valid_pad[grant_idx];

  // Ready goes only to the granted channel and is forced low during reset.
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ready
      assign in_ready[gi] = rst_n && load_en && grant_valid &&
                            (grant_idx == SELW'(gi));
    end
  endgenerate

  // Next-state for the output slot and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (transfer) begin
      out_data_d  = ch_data[grant_idx];
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      if (mode) begin
        ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + SELW'(1);
      end
    end else if (out_ready) begin
      // Drained with nothing to replace it; data and channel keep last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule
